// File: rtl/wb_regbank_pkg.sv
// Shared types and helpers for the Wishbone register bank with interrupt control.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package wb_regbank_pkg;

  // Bus-side handshake state: IDLE waits for CYC&STB, RESP drives the one-cycle termination.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } bus_state_t;

  // Word index of the PENDING register: directly after the data registers.
  function automatic int unsigned pending_idx(input int unsigned nreg);
    return nreg;
  endfunction

  // Word index of the MASK register: directly after PENDING.
  function automatic int unsigned mask_idx(input int unsigned nreg);
    return nreg + 1;
  endfunction

  // Byte lane merge: keep the old byte unless its select bit is set.
  function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/wb_irq_ctrl.sv
// Interrupt controller: PENDING (set by hardware, W1C by software), MASK, and irq = |(PENDING & MASK).
// Latency: raise_irq to pending/irq is one clock; irq is decoded from flops only.
// Backpressure: none; set requests are accepted every cycle.
// Ports: clk/resetn, raise (per-channel set), clr_en + wdata (W1C strobe), mask_we (MASK load),
//        pending/mask (register state), irq (masked OR).
module wb_irq_ctrl
  import wb_regbank_pkg::*;
#(
  parameter int NREG         = 4,
  parameter int IRQ_SET_WINS = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [NREG-1:0] raise,
  input  logic            clr_en,
  input  logic            mask_we,
  input  logic [NREG-1:0] wdata,
  output logic [NREG-1:0] pending,
  output logic [NREG-1:0] mask,
  output logic            irq
);

  logic [NREG-1:0] clr;
  logic [NREG-1:0] pending_d;

  assign clr = clr_en ? wdata : '0;

  // Ordering of the set and clear terms decides who wins on a same-cycle collision.
  always_comb begin
    pending_d = pending;
    if (IRQ_SET_WINS != 0) begin
      pending_d = (pending & ~clr) | raise;
    end else begin
      pending_d = (pending | raise) & ~clr;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending <= '0;
      mask    <= '0;
    end else begin
      pending <= pending_d;
      if (mask_we) begin
        mask <= wdata;
      end
    end
  end

  assign irq = |(pending & mask);

endmodule

// File: rtl/wb_irq_regbank.sv
// Wishbone slave register bank: NREG data registers (byte-enabled), PENDING (W1C) and MASK, plus irq.
// Latency: one cycle request-to-ACK/ERR; a transfer occupies IDLE+RESP, so at least two cycles each.
// Backpressure: none; every request is terminated after one cycle, RTY is never raised.
// Ports: p_clk/p_resetn; Wishbone slave p_wb_* (LOCK ignored); raise_irq in; irq, module_register
//        (register i at [i*DW +: DW]), initialized (sticky per register) and written (write pulse) out.
module wb_irq_regbank
  import wb_regbank_pkg::*;
#(
  parameter int NREG         = 4,
  parameter int DW           = 32,
  parameter int IRQ_SET_WINS = 1
) (
  input  logic               p_clk,
  input  logic               p_resetn,
  input  logic [DW-1:0]      p_wb_DAT_I,
  output logic [DW-1:0]      p_wb_DAT_O,
  input  logic [31:0]        p_wb_ADR_I,
  input  logic [DW/8-1:0]    p_wb_SEL_I,
  input  logic               p_wb_CYC_I,
  input  logic               p_wb_STB_I,
  input  logic               p_wb_WE_I,
  input  logic               p_wb_LOCK_I,
  output logic               p_wb_ACK_O,
  output logic               p_wb_ERR_O,
  output logic               p_wb_RTY_O,
  input  logic [NREG-1:0]    raise_irq,
  output logic               irq,
  output logic [NREG*DW-1:0] module_register,
  output logic [NREG-1:0]    initialized,
  output logic [NREG-1:0]    written
);

  localparam int         SW       = DW / 8;
  localparam logic [4:0] PEND_IDX = 5'(pending_idx(NREG));
  localparam logic [4:0] MASK_IDX = 5'(mask_idx(NREG));

  bus_state_t      state_q, state_d;
  logic            start;
  logic [4:0]      idx;
  logic            is_data, is_pend, is_mask, in_range;
  logic [DW-1:0]   rd_data;
  logic [NREG-1:0] pending, mask;
  logic            unused_bits;

  assign idx      = p_wb_ADR_I[2 +: 5];
  assign is_data  = (idx < 5'(NREG));
  assign is_pend  = (idx == PEND_IDX);
  assign is_mask  = (idx == MASK_IDX);
  assign in_range = is_data | is_pend | is_mask;

  // LOCK and the address bits outside the word index carry no meaning here.
  assign unused_bits = ^{p_wb_ADR_I[31:7], p_wb_ADR_I[1:0], p_wb_LOCK_I};

  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // start marks the IDLE->RESP edge: the only cycle where writes commit and read data is captured.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (p_wb_CYC_I && p_wb_STB_I) begin
          state_d = ST_RESP;
          start   = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Data registers, each with its own sticky initialized flag and write pulse.
  for (genvar g = 0; g < NREG; g++) begin : g_reg
    logic [DW-1:0] q;
    logic [DW-1:0] merged;
    logic          hit;
    logic          init_q;
    logic          wr_q;

    assign hit = start && p_wb_WE_I && (idx == 5'(g));

    always_comb begin
      merged = q;
      for (int b = 0; b < SW; b++) begin
        merged[b*8 +: 8] = byte_merge(q[b*8 +: 8], p_wb_DAT_I[b*8 +: 8], p_wb_SEL_I[b]);
      end
    end

    always_ff @(posedge p_clk or negedge p_resetn) begin
      if (!p_resetn) begin
        q      <= '0;
        init_q <= 1'b0;
        wr_q   <= 1'b0;
      end else begin
        wr_q <= hit;
        if (hit) begin
          q      <= merged;
          init_q <= 1'b1;
        end
      end
    end

    assign module_register[g*DW +: DW] = q;
    assign initialized[g]              = init_q;
    assign written[g]                  = wr_q;
  end

  // Control-register writes use the whole low NREG bits; SEL only gates data-register bytes.
  wb_irq_ctrl #(
    .NREG         (NREG),
    .IRQ_SET_WINS (IRQ_SET_WINS)
  ) u_irq_ctrl (
    .clk     (p_clk),
    .resetn  (p_resetn),
    .raise   (raise_irq),
    .clr_en  (start && p_wb_WE_I && is_pend),
    .mask_we (start && p_wb_WE_I && is_mask),
    .wdata   (p_wb_DAT_I[NREG-1:0]),
    .pending (pending),
    .mask    (mask),
    .irq     (irq)
  );

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NREG; i++) begin
      if (idx == 5'(i)) rd_data = module_register[i*DW +: DW];
    end
    if (is_pend) rd_data = DW'(pending);
    if (is_mask) rd_data = DW'(mask);
  end

  // Termination and read data are registered so they appear only in RESP, for one cycle.
  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      p_wb_ACK_O <= 1'b0;
      p_wb_ERR_O <= 1'b0;
      p_wb_DAT_O <= '0;
    end else begin
      p_wb_ACK_O <= start && in_range;
      p_wb_ERR_O <= start && !in_range;
      p_wb_DAT_O <= (start && !p_wb_WE_I) ? rd_data : '0;
    end
  end

  assign p_wb_RTY_O = 1'b0;

endmodule

// File: tb/tb_wb_irq_regbank.sv
module tb_wb_irq_regbank;

  localparam int NREG = 4;
  localparam int DW   = 32;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [DW-1:0]      dat_i = '0;
  logic [31:0]        adr = '0;
  logic [3:0]         sel = '0;
  logic               cyc = 1'b0, stb = 1'b0, we = 1'b0, lock = 1'b0;
  logic [NREG-1:0]    raise = '0;

  // set-wins instance
  logic [DW-1:0]      dat_o;
  logic               ack, err, rty, irq;
  logic [NREG*DW-1:0] modreg;
  logic [NREG-1:0]    init_o, written;
  // clear-wins instance
  logic [DW-1:0]      dat_o_b;
  logic               ack_b, err_b, rty_b, irq_b;
  logic [NREG*DW-1:0] modreg_b;
  logic [NREG-1:0]    init_b, written_b;

  always #5 clk = ~clk;

  wb_irq_regbank #(.NREG(NREG), .DW(DW), .IRQ_SET_WINS(1)) dut (
    .p_clk(clk), .p_resetn(rst_n), .p_wb_DAT_I(dat_i), .p_wb_DAT_O(dat_o), .p_wb_ADR_I(adr),
    .p_wb_SEL_I(sel), .p_wb_CYC_I(cyc), .p_wb_STB_I(stb), .p_wb_WE_I(we), .p_wb_LOCK_I(lock),
    .p_wb_ACK_O(ack), .p_wb_ERR_O(err), .p_wb_RTY_O(rty), .raise_irq(raise), .irq(irq),
    .module_register(modreg), .initialized(init_o), .written(written));

  wb_irq_regbank #(.NREG(NREG), .DW(DW), .IRQ_SET_WINS(0)) dut_b (
    .p_clk(clk), .p_resetn(rst_n), .p_wb_DAT_I(dat_i), .p_wb_DAT_O(dat_o_b), .p_wb_ADR_I(adr),
    .p_wb_SEL_I(sel), .p_wb_CYC_I(cyc), .p_wb_STB_I(stb), .p_wb_WE_I(we), .p_wb_LOCK_I(lock),
    .p_wb_ACK_O(ack_b), .p_wb_ERR_O(err_b), .p_wb_RTY_O(rty_b), .raise_irq(raise), .irq(irq_b),
    .module_register(modreg_b), .initialized(init_b), .written(written_b));

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  // Behavioural model of the register map.
  logic [DW-1:0]   m_reg [NREG];
  logic [NREG-1:0] m_pend1, m_pend0, m_mask, m_init;
  logic            exp_ack, exp_err, exp_rd_vld;
  logic [NREG-1:0] exp_written;
  logic [DW-1:0]   exp_rd, exp_rd0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [NREG*DW-1:0] m_flat();
    logic [NREG*DW-1:0] f;
    for (int i = 0; i < NREG; i++) f[i*DW +: DW] = m_reg[i];
    return f;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NREG; i++) m_reg[i] = '0;
    m_pend1 = '0; m_pend0 = '0; m_mask = '0; m_init = '0;
    exp_ack = 0; exp_err = 0; exp_rd_vld = 0; exp_written = '0; exp_rd = '0; exp_rd0 = '0;
  endtask

  // Effect of one clock edge, given what the bus and raise_irq presented before it.
  task automatic model_edge(input logic req, input logic w, input logic [4:0] idx,
                            input logic [31:0] d, input logic [3:0] s, input logic [3:0] r);
    logic [NREG-1:0] clr;
    clr = '0;
    exp_ack = 0; exp_err = 0; exp_rd_vld = 0; exp_written = '0;
    if (req) begin
      exp_rd_vld = !w;
      exp_rd = '0; exp_rd0 = '0;
      if (idx < NREG) begin
        exp_ack = 1;
        if (w) begin
          for (int b = 0; b < 4; b++) if (s[b]) m_reg[idx][b*8 +: 8] = d[b*8 +: 8];
          m_init[idx] = 1'b1;
          exp_written[idx] = 1'b1;
        end else begin
          exp_rd = m_reg[idx]; exp_rd0 = m_reg[idx];
        end
      end else if (idx == NREG) begin
        exp_ack = 1;
        if (w) clr = d[NREG-1:0];
        else begin exp_rd = 32'(m_pend1); exp_rd0 = 32'(m_pend0); end
      end else if (idx == NREG + 1) begin
        exp_ack = 1;
        if (w) m_mask = d[NREG-1:0];
        else begin exp_rd = 32'(m_mask); exp_rd0 = 32'(m_mask); end
      end else begin
        exp_err = 1;
      end
    end
    for (int i = 0; i < NREG; i++) begin
      if (r[i] && clr[i]) begin m_pend1[i] = 1'b1; m_pend0[i] = 1'b0; end
      else if (r[i])      begin m_pend1[i] = 1'b1; m_pend0[i] = 1'b1; end
      else if (clr[i])    begin m_pend1[i] = 1'b0; m_pend0[i] = 1'b0; end
    end
  endtask

  // Present inputs for one cycle, let the edge happen, then advance the model.
  task automatic cycle(input logic req, input logic w, input logic [4:0] idx,
                       input logic [31:0] d, input logic [3:0] s, input logic [3:0] r);
    cyc = req; stb = req; we = w; lock = req; dat_i = d; sel = s; raise = r;
    adr = {25'h0A5A5A5, idx, 2'b11};
    @(posedge clk); #1;
    model_edge(req, w, idx, d, s, r);
    cyc = 0; stb = 0; we = 0; lock = 0; raise = '0;
  endtask

  task automatic xfer(input logic w, input logic [4:0] idx, input logic [31:0] d,
                      input logic [3:0] s, input logic [3:0] r,
                      output logic [31:0] rd, output logic [31:0] rd0);
    cycle(1'b1, w, idx, d, s, r);
    rd = dat_o; rd0 = dat_o_b;
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 4'd0, 4'd0);
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ack", ack, exp_ack);
      chk("err", err, exp_err);
      chk("ack_b", ack_b, exp_ack);
      chk("err_b", err_b, exp_err);
      chk("rty", {rty, rty_b}, 2'b00);
      chk("written", written, exp_written);
      chk("initialized", init_o, m_init);
      chk("module_register", modreg, m_flat());
      chk("module_register_b", modreg_b, m_flat());
      chk("irq", irq, |(m_pend1 & m_mask));
      chk("irq_b", irq_b, |(m_pend0 & m_mask));
      if (exp_rd_vld) begin
        chk("dat_o", dat_o, exp_rd);
        chk("dat_o_b", dat_o_b, exp_rd0);
      end
    end
  end

  logic [31:0] rd, rd0;

  initial begin
    m_reset();
    #2 rst_n = 1'b0;
    cmp_en = 1'b1;
    @(posedge clk); #1;
    chk("reset_ack", ack, 1'b0);
    chk("reset_dat", dat_o, 32'd0);
    chk("reset_regs", modreg, 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Full-word write, ACK and written[2] in the RESP cycle, then read back.
    cycle(1'b1, 1'b1, 5'd2, 32'hDEADBEEF, 4'hF, 4'h0);
    chk("w2_ack", ack, 1'b1);
    chk("w2_written", written, 4'b0100);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 4'd0, 4'd0);
    chk("w2_ack_gone", ack, 1'b0);
    chk("w2_reg", modreg[95:64], 32'hDEADBEEF);
    chk("w2_init", init_o, 4'b0100);
    xfer(1'b0, 5'd2, 32'd0, 4'hF, 4'h0, rd, rd0);
    chk("r2_data", rd, 32'hDEADBEEF);

    // Byte-lane merge.
    xfer(1'b1, 5'd0, 32'h11223344, 4'hF, 4'h0, rd, rd0);
    xfer(1'b1, 5'd0, 32'hAABBCCDD, 4'h5, 4'h0, rd, rd0);
    xfer(1'b0, 5'd0, 32'd0, 4'hF, 4'h0, rd, rd0);
    chk("r0_merge", rd, 32'h11BB33DD);

    // SEL=0 write: acknowledged, flags update, data unchanged.
    xfer(1'b1, 5'd1, 32'hFFFFFFFF, 4'h0, 4'h0, rd, rd0);
    chk("sel0_init", init_o, 4'b0111);
    chk("sel0_reg", modreg[63:32], 32'd0);

    // Out-of-range read and write.
    cycle(1'b1, 1'b0, 5'd6, 32'd0, 4'hF, 4'h0);
    chk("oor_err", {err, ack}, 2'b10);
    chk("oor_dat", dat_o, 32'd0);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 4'd0, 4'd0);
    xfer(1'b1, 5'd7, 32'hFFFFFFFF, 4'hF, 4'h0, rd, rd0);

    // Masked interrupt, W1C, then unmasked pending.
    xfer(1'b1, 5'd5, 32'h2, 4'hF, 4'h0, rd, rd0);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 4'd0, 4'b0010);
    chk("irq_raise", irq, 1'b1);
    xfer(1'b0, 5'd4, 32'd0, 4'hF, 4'h0, rd, rd0);
    chk("pend_2", rd, 32'h2);
    xfer(1'b1, 5'd4, 32'h2, 4'hF, 4'h0, rd, rd0);
    chk("irq_w1c", irq, 1'b0);
    xfer(1'b1, 5'd5, 32'h0, 4'hF, 4'h0, rd, rd0);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 4'd0, 4'b1000);
    xfer(1'b0, 5'd4, 32'd0, 4'hF, 4'h0, rd, rd0);
    chk("pend_8", rd, 32'h8);
    chk("irq_masked", irq, 1'b0);

    // Same-edge set and W1C of bit 0 on both priority variants.
    xfer(1'b1, 5'd4, 32'h1, 4'hF, 4'b0001, rd, rd0);
    xfer(1'b0, 5'd4, 32'd0, 4'hF, 4'h0, rd, rd0);
    chk("setwins_pend", rd, 32'h9);
    chk("clrwins_pend", rd0, 32'h8);

    // MASK is NREG bits wide; upper bits read 0.
    xfer(1'b1, 5'd5, 32'hFFFFFFFF, 4'hF, 4'h0, rd, rd0);
    xfer(1'b0, 5'd5, 32'd0, 4'hF, 4'h0, rd, rd0);
    chk("mask_width", rd, 32'hF);
    chk("irq_on", {irq, irq_b}, 2'b11);

    // Reset during RESP aborts the transfer with no clock edge.
    cycle(1'b1, 1'b1, 5'd3, 32'h12345678, 4'hF, 4'h0);
    chk("pre_rst_ack", ack, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ack", {ack, ack_b, err}, 3'b000);
    chk("rst_irq", {irq, irq_b}, 2'b00);
    chk("rst_regs", modreg, 128'd0);
    chk("rst_flags", {init_o, written}, 8'd0);
    chk("rst_dat", dat_o, 32'd0);
    m_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    cycle(1'b1, 1'b1, 5'd2, 32'hDEADBEEF, 4'hF, 4'h0);
    chk("post_rst_ack", ack, 1'b1);
    chk("post_rst_written", written, 4'b0100);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 4'd0, 4'd0);
    xfer(1'b0, 5'd2, 32'd0, 4'hF, 4'h0, rd, rd0);
    chk("post_rst_read", rd, 32'hDEADBEEF);
    chk("post_rst_init", init_o, 4'b0100);

    repeat (3) @(posedge clk);
    #1;
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_irq_regbank.md
WB_IRQ_REGBANK -- requirements
Module: wb_irq_regbank

Interface
REQ-001 The block SHALL have parameter NREG, default 4: number of data registers, 1..16.
REQ-002 The block SHALL have parameter DW, default 32: data register and bus width, multiple of 8.
REQ-003 The block SHALL have parameter IRQ_SET_WINS, default 1: when 1, a hardware set beats a simultaneous software clear.
REQ-004 The block SHALL have port p_clk, in, 1: the single clock, rising edge.
REQ-005 The block SHALL have port p_resetn, in, 1: reset, asynchronous, active-low.
REQ-006 The block SHALL have ports p_wb_DAT_I (in, DW), p_wb_DAT_O (out, DW), p_wb_ADR_I (in, 32), p_wb_SEL_I (in, DW/8), p_wb_CYC_I, p_wb_STB_I, p_wb_WE_I and p_wb_LOCK_I (in, 1 each): the Wishbone slave inputs and read data.
REQ-007 The block SHALL have ports p_wb_ACK_O, p_wb_ERR_O and p_wb_RTY_O, out, 1 each: transfer termination.
REQ-008 The block SHALL have port raise_irq, in, NREG: per-channel interrupt set request, sampled each cycle.
REQ-009 The block SHALL have port irq, out, 1: the OR of pending AND mask.
REQ-010 The block SHALL have port module_register, out, NREG*DW: all data registers, with register i at [i*DW +: DW].
REQ-011 The block SHALL have ports initialized and written, out, NREG each: initialized[i] is sticky after the first write to register i; written[i] pulses for one cycle on each write to register i.

Function
REQ-012 The word index SHALL be p_wb_ADR_I[2 +: 5]; index 0..NREG-1 selects the data registers, NREG selects PENDING, NREG+1 selects MASK, and any other index is out-of-range.
REQ-013 The bus FSM SHALL have two states: IDLE, which moves to RESP when CYC&STB is high, and RESP, which always returns to IDLE.
REQ-014 The block SHALL perform writes and capture read data on the IDLE->RESP edge, and SHALL drive ACK or ERR only in RESP, for exactly one cycle.
REQ-015 Latency SHALL be one cycle from request to termination, so back-to-back transfers cost at least two cycles each.
REQ-016 An out-of-range access SHALL assert ERR instead of ACK, change no state and return read data 0.
REQ-017 A data-register write SHALL update only the bytes enabled by SEL; a write with SEL all-zero SHALL still be ACKed, and SHALL still pulse written and set initialized.
REQ-018 written[i] SHALL be high in the same cycle as the ACK of the write to register i.
REQ-019 PENDING SHALL be NREG bits; raise_irq[i] high sets bit i on the next edge, and a write of 1 to bit i clears it (W1C).
REQ-020 When a set and a clear of the same PENDING bit occur in the same cycle, set SHALL win if IRQ_SET_WINS=1, otherwise clear SHALL win.
REQ-021 MASK SHALL be a plain NREG-bit read/write register, and PENDING and MASK bits at or above NREG SHALL read 0.
REQ-022 irq SHALL be computed combinationally from flops only, so it goes high one cycle after raise_irq when the mask bit is set.
REQ-023 RTY SHALL be tied to 0, and LOCK SHALL be ignored.
REQ-024 If CYC drops while the FSM is in RESP, the FSM SHALL still return to IDLE and the completed write SHALL stand.

Reset
REQ-025 While p_resetn is low, all of the following SHALL be forced to 0 immediately: FSM (IDLE), ACK, ERR, DAT_O, the data registers, PENDING, MASK, irq, initialized and written.
REQ-026 A reset asserted mid-transfer SHALL abort the transfer, and no ACK or ERR SHALL be produced for it.
REQ-027 Reset release SHALL take effect on the first rising p_clk edge after p_resetn goes high.

Structure
REQ-028 Package wb_regbank_pkg SHALL hold the FSM state enum, the PENDING and MASK offset functions (NREG and NREG+1), and the byte-merge function.
REQ-029 Sub-module wb_irq_ctrl SHALL hold PENDING, MASK, the set/clear priority logic and irq generation.

Verification
REQ-030 Write 0xDEADBEEF to index 2 with SEL=0xF -> ACK one cycle later for exactly one cycle, written[2] pulses, initialized[2]=1, register 2 reads 0xDEADBEEF.
REQ-031 Write 0x11223344 then 0xAABBCCDD with SEL=0x5 to index 0 -> register 0 reads 0x11BB33DD.
REQ-032 Read index NREG+2 (=6) -> ERR for one cycle, ACK=0, DAT_O=0, no state change.
REQ-033 Set MASK=0x2, pulse raise_irq[1] -> PENDING=0x2 and irq=1 on the next cycle; W1C 0x2 -> irq=0; with MASK=0 a raise_irq[3] gives PENDING=0x8 and irq=0.
REQ-034 raise_irq[0] in the same cycle as a W1C of bit 0 -> PENDING[0]=1 with IRQ_SET_WINS=1, and 0 with IRQ_SET_WINS=0.
REQ-035 Assert p_resetn=0 while in RESP -> ACK drops with no clock edge, all outputs are 0, and the first access after release behaves as in REQ-030.
